// File: rtl/atriusb_event_framer.sv
// Frames each IRS event stream into one or more FIFO frames of two header words
// plus payload, starting a frame only once the FIFO has room for all of it.
module atriusb_event_framer #(
    parameter int unsigned MAX_FRAME_WORDS = 1024,
    parameter logic [7:0]  TYPE_BASE       = 8'hE0,
    parameter int unsigned SPACE_MARGIN    = 4
) (
    input  logic        irs_clk_i,
    input  logic        rst_n_i,
    input  logic        ev_start_i,
    input  logic [15:0] ev_nwords_i,
    output logic        ev_start_ready_o,
    input  logic [15:0] dat_i,
    input  logic        dat_valid_i,
    output logic        dat_ready_o,
    output logic [15:0] fifo_dat_o,
    output logic        fifo_wr_o,
    input  logic        fifo_full_i,
    input  logic [15:0] fifo_nwords_i,
    output logic        err_zero_len_o,
    output logic        overflow_o,
    output logic [23:0] debug_o
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CMP_W  = WORD_W + 1;
    localparam int unsigned FNUM_W = 8;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SPACE_WAIT = 3'd1,
        S_HDR0       = 3'd2,
        S_HDR1       = 3'd3,
        S_PAYLOAD    = 3'd4,
        S_FRAME_DONE = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   remaining_q, remaining_d;
    logic [WORD_W-1:0]   flen_q, flen_d;
    logic [WORD_W-1:0]   pcnt_q, pcnt_d;
    logic [FNUM_W-1:0]   fnum_q, fnum_d;
    logic [WORD_W-1:0]   fifo_dat_q, fifo_dat_d;
    logic                fifo_wr_q, fifo_wr_d;
    logic                err_q, err_d;
    logic                ovf_q, ovf_d;

    logic [WORD_W-1:0]   rem_after;
    logic [CMP_W-1:0]    space_need;
    logic                space_ok;

    // Frame length is the remaining event length clipped to the frame limit.
    function automatic logic [WORD_W-1:0] clip_len(input logic [WORD_W-1:0] n);
        return (n > WORD_W'(MAX_FRAME_WORDS)) ? WORD_W'(MAX_FRAME_WORDS) : n;
    endfunction

    // 17-bit compare so the header + margin addition can never wrap.
    assign space_need = CMP_W'(flen_q) + CMP_W'(2) + CMP_W'(SPACE_MARGIN);
    assign space_ok   = !fifo_full_i && ({1'b0, fifo_nwords_i} >= space_need);
    assign rem_after  = remaining_q - flen_q;

    always_ff @(posedge irs_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            flen_q      <= '0;
            pcnt_q      <= '0;
            fnum_q      <= '0;
            fifo_dat_q  <= '0;
            fifo_wr_q   <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            flen_q      <= flen_d;
            pcnt_q      <= pcnt_d;
            fnum_q      <= fnum_d;
            fifo_dat_q  <= fifo_dat_d;
            fifo_wr_q   <= fifo_wr_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        flen_d      = flen_q;
        pcnt_d      = pcnt_q;
        fnum_d      = fnum_q;
        fifo_dat_d  = fifo_dat_q;
        fifo_wr_d   = 1'b0;
        err_d       = 1'b0;
        ovf_d       = ovf_q;
        dat_ready_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ev_start_i) begin
                    if (ev_nwords_i == '0) begin
                        err_d = 1'b1;
                    end else begin
                        remaining_d = ev_nwords_i;
                        flen_d      = clip_len(ev_nwords_i);
                        fnum_d      = '0;
                        state_d     = S_SPACE_WAIT;
                    end
                end
            end
            S_SPACE_WAIT: begin
                if (space_ok) state_d = S_HDR0;
            end
            // Header writes also hold off on full so no write ever lands on a full FIFO.
            S_HDR0: begin
                if (!fifo_full_i) begin
                    fifo_wr_d  = 1'b1;
                    fifo_dat_d = {TYPE_BASE[7:2], (fnum_q == '0), (remaining_q == flen_q), fnum_q};
                    state_d    = S_HDR1;
                end
            end
            S_HDR1: begin
                if (!fifo_full_i) begin
                    fifo_wr_d  = 1'b1;
                    fifo_dat_d = flen_q;
                    pcnt_d     = flen_q;
                    state_d    = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                dat_ready_o = !fifo_full_i;
                if (fifo_full_i) ovf_d = 1'b1;
                if (dat_valid_i && !fifo_full_i) begin
                    fifo_wr_d  = 1'b1;
                    fifo_dat_d = dat_i;
                    pcnt_d     = pcnt_q - WORD_W'(1);
                    if (pcnt_q == WORD_W'(1)) state_d = S_FRAME_DONE;
                end
            end
            S_FRAME_DONE: begin
                remaining_d = rem_after;
                fnum_d      = fnum_q + FNUM_W'(1);
                if (rem_after == '0) begin
                    state_d = S_IDLE;
                end else begin
                    flen_d  = clip_len(rem_after);
                    state_d = S_SPACE_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ev_start_ready_o = (state_q == S_IDLE);
    assign fifo_dat_o       = fifo_dat_q;
    assign fifo_wr_o        = fifo_wr_q;
    assign err_zero_len_o   = err_q;
    assign overflow_o       = ovf_q;
    assign debug_o          = {fnum_q, state_q, remaining_q[12:0]};

endmodule

// File: tb/tb_atriusb_event_framer.sv
// Directed bench for atriusb_event_framer: expected FIFO words are queued at event
// start and checked in order as the DUT writes them.
module tb_atriusb_event_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ev_start;
    logic [15:0] ev_nwords;
    logic        ev_start_ready;
    logic [15:0] dat;
    logic        dat_valid;
    logic        dat_ready;
    logic [15:0] fifo_dat;
    logic        fifo_wr;
    logic        fifo_full;
    logic [15:0] fifo_nwords;
    logic        err_zero_len;
    logic        overflow;
    logic [23:0] debug;

    int passed = 0;
    int total  = 0;
    int wr_count = 0;
    logic prev_full = 1'b0;
    logic [15:0] exp_q[$];

    atriusb_event_framer dut (
        .irs_clk_i        (clk),
        .rst_n_i          (rst_n),
        .ev_start_i       (ev_start),
        .ev_nwords_i      (ev_nwords),
        .ev_start_ready_o (ev_start_ready),
        .dat_i            (dat),
        .dat_valid_i      (dat_valid),
        .dat_ready_o      (dat_ready),
        .fifo_dat_o       (fifo_dat),
        .fifo_wr_o        (fifo_wr),
        .fifo_full_i      (fifo_full),
        .fifo_nwords_i    (fifo_nwords),
        .err_zero_len_o   (err_zero_len),
        .overflow_o       (overflow),
        .debug_o          (debug)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] word(input logic [15:0] base, input int i);
        return base + 16'(i * 13);
    endfunction

    // Write monitor: every FIFO write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && fifo_wr) begin
            wr_count++;
            chk("wr_while_full", 32'(prev_full), 32'(0));
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(fifo_dat), 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("fifo_dat", 32'(fifo_dat), 32'(e));
            end
        end
        prev_full = fifo_full;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_event(input int n, input logic [15:0] base);
        int rem;
        int k;
        int idx;
        int fl;
        rem = n; k = 0; idx = 0;
        while (rem > 0) begin
            fl = (rem > 1024) ? 1024 : rem;
            exp_q.push_back({6'b111000, (k == 0), (rem == fl), 8'(k)});
            exp_q.push_back(16'(fl));
            for (int j = 0; j < fl; j++) begin
                exp_q.push_back(word(base, idx));
                idx++;
            end
            rem -= fl;
            k++;
        end
        ev_start  = 1'b1;
        ev_nwords = 16'(n);
        step();
        ev_start  = 1'b0;
    endtask

    task automatic feed(input int n, input logic [15:0] base, input int gap_pct,
                        input int full_at, input int limit);
        int i;
        int c;
        logic acc;
        i = 0; c = 0;
        while (i < n && c < limit) begin
            dat_valid = ($urandom_range(99) >= 32'(gap_pct));
            dat       = word(base, i);
            fifo_full = (full_at >= 0 && c >= full_at && c < full_at + 3);
            @(negedge clk);
            acc = dat_valid && dat_ready;
            step();
            if (acc) i++;
            c++;
        end
        dat_valid = 1'b0;
        fifo_full = 1'b0;
        if (i < n) chk("feed_timeout", 32'(i), 32'(n));
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while (!ev_start_ready && k < limit) begin
            step();
            k++;
        end
        if (!ev_start_ready) chk("idle_timeout", 32'(ev_start_ready), 32'(1));
    endtask

    initial begin
        int w0;
        rst_n = 1'b0; ev_start = 1'b0; ev_nwords = '0; dat = '0; dat_valid = 1'b0;
        fifo_full = 1'b0; fifo_nwords = 16'hFFFF;
        #1;
        chk("rst_fifo_wr", 32'(fifo_wr), 32'(0));
        chk("rst_fifo_dat", 32'(fifo_dat), 32'(0));
        chk("rst_dat_ready", 32'(dat_ready), 32'(0));
        chk("rst_err", 32'(err_zero_len), 32'(0));
        chk("rst_ovf", 32'(overflow), 32'(0));
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(ev_start_ready), 32'(1));

        // 1: single 100-word frame
        w0 = wr_count;
        start_event(100, 16'h1000);
        feed(100, 16'h1000, 0, -1, 500);
        wait_idle(50);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'(0));
        chk("t1_writes", 32'(wr_count - w0), 32'(102));

        // 2: 2500 words split into 1024/1024/452
        w0 = wr_count;
        start_event(2500, 16'h2000);
        feed(2500, 16'h2000, 0, -1, 5000);
        wait_idle(50);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'(0));
        chk("t2_writes", 32'(wr_count - w0), 32'(2506));

        // 3: space check threshold (1024 + 2 + 4)
        fifo_nwords = 16'd500;
        w0 = wr_count;
        start_event(1024, 16'h3000);
        repeat (20) step();
        chk("t3_no_wr_500", 32'(wr_count - w0), 32'(0));
        chk("t3_busy", 32'(ev_start_ready), 32'(0));
        chk("t3_not_ready", 32'(dat_ready), 32'(0));
        fifo_nwords = 16'd1029;
        repeat (20) step();
        chk("t3_no_wr_1029", 32'(wr_count - w0), 32'(0));
        fifo_nwords = 16'd1030;
        repeat (4) step();
        chk("t3_hdr_wr_1030", 32'(wr_count - w0), 32'(2));
        feed(1024, 16'h3000, 0, -1, 3000);
        wait_idle(50);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'(0));
        fifo_nwords = 16'hFFFF;

        // 4: zero-length start
        w0 = wr_count;
        ev_start = 1'b1; ev_nwords = 16'd0;
        step();
        ev_start = 1'b0;
        chk("t4_err_pulse", 32'(err_zero_len), 32'(1));
        chk("t4_ready_hold", 32'(ev_start_ready), 32'(1));
        step();
        chk("t4_err_clear", 32'(err_zero_len), 32'(0));
        repeat (3) step();
        chk("t4_no_write", 32'(wr_count - w0), 32'(0));
        chk("t4_ready", 32'(ev_start_ready), 32'(1));
        chk("t4_ovf_clear", 32'(overflow), 32'(0));

        // 5: reset in the middle of a 300-word payload
        start_event(300, 16'h5000);
        feed(50, 16'h5000, 0, -1, 500);
        rst_n = 1'b0;
        #1;
        chk("t5_wr_in_rst", 32'(fifo_wr), 32'(0));
        chk("t5_rdy_in_rst", 32'(dat_ready), 32'(0));
        step();
        rst_n = 1'b1;
        exp_q.delete();
        step();
        chk("t5_idle_after", 32'(ev_start_ready), 32'(1));
        w0 = wr_count;
        start_event(10, 16'h5500);
        feed(10, 16'h5500, 0, -1, 100);
        wait_idle(50);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'(0));
        chk("t5_writes", 32'(wr_count - w0), 32'(12));

        // 6: random valid gaps plus a full pulse during payload
        w0 = wr_count;
        start_event(300, 16'h6000);
        feed(300, 16'h6000, 30, 20, 3000);
        wait_idle(50);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'(0));
        chk("t6_writes", 32'(wr_count - w0), 32'(302));
        chk("t6_overflow", 32'(overflow), 32'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
